// File: rtl/conn_lookup_initiator.sv
// Requester side of the connection-manager forward lookup: issues tagged keys,
// pairs in-order responses with their tags, and keeps hit/miss statistics.
module conn_lookup_initiator #(
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned TAG_W           = 8
) (
    input  logic                              s00_axis_aclk,
    input  logic                              s00_axis_aresetn,
    input  logic                              s00_axis_tvalid,
    output logic                              s00_axis_tready,
    input  logic [63:0]                       s00_axis_tdata,
    input  logic [TAG_W-1:0]                  s00_axis_tuser,
    output logic                              m00_axis_tvalid,
    input  logic                              m00_axis_tready,
    output logic [63:0]                       m00_axis_tdata,
    output logic                              m00_axis_tlast,
    output logic [7:0]                        m00_axis_tstrb,
    input  logic                              s01_axis_tvalid,
    output logic                              s01_axis_tready,
    input  logic [63:0]                       s01_axis_tdata,
    output logic                              m01_axis_tvalid,
    input  logic                              m01_axis_tready,
    output logic [63:0]                       m01_axis_tdata,
    output logic [TAG_W-1:0]                  m01_axis_tuser,
    output logic [$clog2(MAX_OUTSTANDING):0]  outstanding,
    output logic [31:0]                       hit_count,
    output logic [31:0]                       miss_count,
    output logic                              unexpected_resp
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING) + 1;
    localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);

    logic [TAG_W-1:0] tag_mem [MAX_OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             s00_hs;
    logic             s01_hs;
    logic             fifo_empty;
    logic             pop;
    logic             drop;
    logic             resp_hit;
    logic             unused_resp_bits;

    assign m00_axis_tlast = 1'b1;
    assign m00_axis_tstrb = 8'hFF;

    // Full/empty come from the registered in-flight count, so a pop never enables an accept in the same cycle.
    assign s00_axis_tready = s00_axis_aresetn
                           && (outstanding < CNT_W'(MAX_OUTSTANDING))
                           && (!m00_axis_tvalid || m00_axis_tready);
    assign s01_axis_tready = !m01_axis_tvalid || m01_axis_tready;

    assign s00_hs           = s00_axis_tvalid && s00_axis_tready;
    assign s01_hs           = s01_axis_tvalid && s01_axis_tready;
    assign fifo_empty       = (outstanding == '0);
    assign pop              = s01_hs && !fifo_empty;
    assign drop             = s01_hs && fifo_empty;
    assign resp_hit         = s01_axis_tdata[32];
    assign unused_resp_bits = ^s01_axis_tdata[63:33];

    // Tag storage needs no reset; validity is tracked by the pointers and count.
    always_ff @(posedge s00_axis_aclk) begin
        if (s00_hs) begin
            tag_mem[wr_ptr] <= s00_axis_tuser;
        end
    end

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            outstanding     <= '0;
            m00_axis_tvalid <= 1'b0;
            m00_axis_tdata  <= '0;
            m01_axis_tvalid <= 1'b0;
            m01_axis_tdata  <= '0;
            m01_axis_tuser  <= '0;
            hit_count       <= '0;
            miss_count      <= '0;
            unexpected_resp <= 1'b0;
        end else begin
            unexpected_resp <= drop;

            if (s00_hs) begin
                m00_axis_tvalid <= 1'b1;
                m00_axis_tdata  <= s00_axis_tdata;
                wr_ptr          <= wr_ptr + PTR_W'(1);
            end else if (m00_axis_tready) begin
                m00_axis_tvalid <= 1'b0;
            end

            if (pop) begin
                m01_axis_tvalid <= 1'b1;
                m01_axis_tdata  <= {31'b0, s01_axis_tdata[32:0]};
                m01_axis_tuser  <= tag_mem[rd_ptr];
                rd_ptr          <= rd_ptr + PTR_W'(1);
                if (resp_hit) begin
                    hit_count <= hit_count + 32'd1;
                end else begin
                    miss_count <= miss_count + 32'd1;
                end
            end else if (m01_axis_tready) begin
                m01_axis_tvalid <= 1'b0;
            end

            case ({s00_hs, pop})
                2'b10:   outstanding <= outstanding + CNT_W'(1);
                2'b01:   outstanding <= outstanding - CNT_W'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

endmodule

// File: tb/tb_conn_lookup_initiator.sv
// Directed self-checking bench for conn_lookup_initiator (MAX_OUTSTANDING=4, TAG_W=8).
module tb_conn_lookup_initiator;

    localparam int unsigned MAX_OUT = 4;
    localparam int unsigned TAG_W   = 8;
    localparam int unsigned OW      = $clog2(MAX_OUT) + 1;

    logic              clk;
    logic              aresetn;
    logic              s00_tvalid, s00_tready;
    logic [63:0]       s00_tdata;
    logic [TAG_W-1:0]  s00_tuser;
    logic              m00_tvalid, m00_tready, m00_tlast;
    logic [63:0]       m00_tdata;
    logic [7:0]        m00_tstrb;
    logic              s01_tvalid, s01_tready;
    logic [63:0]       s01_tdata;
    logic              m01_tvalid, m01_tready;
    logic [63:0]       m01_tdata;
    logic [TAG_W-1:0]  m01_tuser;
    logic [OW-1:0]     outstanding;
    logic [31:0]       hit_count, miss_count;
    logic              unexpected_resp;

    int          n_tests;
    int          n_fail;
    logic [31:0] exp_hit;
    logic [31:0] exp_miss;

    conn_lookup_initiator #(.MAX_OUTSTANDING(MAX_OUT), .TAG_W(TAG_W)) dut (
        .s00_axis_aclk    (clk),
        .s00_axis_aresetn (aresetn),
        .s00_axis_tvalid  (s00_tvalid),
        .s00_axis_tready  (s00_tready),
        .s00_axis_tdata   (s00_tdata),
        .s00_axis_tuser   (s00_tuser),
        .m00_axis_tvalid  (m00_tvalid),
        .m00_axis_tready  (m00_tready),
        .m00_axis_tdata   (m00_tdata),
        .m00_axis_tlast   (m00_tlast),
        .m00_axis_tstrb   (m00_tstrb),
        .s01_axis_tvalid  (s01_tvalid),
        .s01_axis_tready  (s01_tready),
        .s01_axis_tdata   (s01_tdata),
        .m01_axis_tvalid  (m01_tvalid),
        .m01_axis_tready  (m01_tready),
        .m01_axis_tdata   (m01_tdata),
        .m01_axis_tuser   (m01_tuser),
        .outstanding      (outstanding),
        .hit_count        (hit_count),
        .miss_count       (miss_count),
        .unexpected_resp  (unexpected_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        @(posedge clk); #1;
        aresetn = 1'b0; s00_tvalid = 1'b0; s01_tvalid = 1'b0;
        m00_tready = 1'b1; m01_tready = 1'b1;
        repeat (2) @(posedge clk);
        #1 aresetn = 1'b1;
        exp_hit = '0; exp_miss = '0;
    endtask

    task automatic test_reset();
        #2 aresetn = 1'b0;
        #1;
        n_tests++; if (s00_tready !== 1'b0) begin n_fail++; $display("FAIL rst_s00_tready: got %b want 0", s00_tready); end
        n_tests++; if (m00_tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_m00_tvalid: got %b want 0", m00_tvalid); end
        n_tests++; if (m01_tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_m01_tvalid: got %b want 0", m01_tvalid); end
        n_tests++; if (outstanding !== OW'(0)) begin n_fail++; $display("FAIL rst_outstanding: got %0d want 0", outstanding); end
        n_tests++; if (hit_count !== 32'd0) begin n_fail++; $display("FAIL rst_hit: got %0d want 0", hit_count); end
        n_tests++; if (miss_count !== 32'd0) begin n_fail++; $display("FAIL rst_miss: got %0d want 0", miss_count); end
        n_tests++; if (unexpected_resp !== 1'b0) begin n_fail++; $display("FAIL rst_unexpected: got %b want 0", unexpected_resp); end
        n_tests++; if (m00_tlast !== 1'b1) begin n_fail++; $display("FAIL const_tlast: got %b want 1", m00_tlast); end
        n_tests++; if (m00_tstrb !== 8'hFF) begin n_fail++; $display("FAIL const_tstrb: got %h want ff", m00_tstrb); end
        @(posedge clk); #1 aresetn = 1'b1;
        exp_hit = '0; exp_miss = '0;
    endtask

    task automatic test_single();
        s00_tvalid = 1'b1; s00_tdata = 64'h0000_0000_0A00_0001; s00_tuser = 8'h5A;
        #1;
        n_tests++; if (s00_tready !== 1'b1) begin n_fail++; $display("FAIL single_s00_tready: got %b want 1", s00_tready); end
        @(posedge clk); #1; s00_tvalid = 1'b0;
        n_tests++; if (m00_tvalid !== 1'b1) begin n_fail++; $display("FAIL single_m00_tvalid: got %b want 1", m00_tvalid); end
        n_tests++; if (m00_tdata !== 64'h0000_0000_0A00_0001) begin n_fail++; $display("FAIL single_m00_tdata: got %h want 0a000001", m00_tdata); end
        n_tests++; if (outstanding !== OW'(1)) begin n_fail++; $display("FAIL single_out1: got %0d want 1", outstanding); end
        s01_tvalid = 1'b1; s01_tdata = 64'h0000_0001_0000_0007;
        @(posedge clk); #1; s01_tvalid = 1'b0; exp_hit++;
        n_tests++; if (m01_tvalid !== 1'b1) begin n_fail++; $display("FAIL single_m01_tvalid: got %b want 1", m01_tvalid); end
        n_tests++; if (m01_tdata !== 64'h0000_0001_0000_0007) begin n_fail++; $display("FAIL single_m01_tdata: got %h want 100000007", m01_tdata); end
        n_tests++; if (m01_tuser !== 8'h5A) begin n_fail++; $display("FAIL single_m01_tuser: got %h want 5a", m01_tuser); end
        n_tests++; if (hit_count !== exp_hit) begin n_fail++; $display("FAIL single_hit: got %0d want %0d", hit_count, exp_hit); end
        n_tests++; if (outstanding !== OW'(0)) begin n_fail++; $display("FAIL single_out0: got %0d want 0", outstanding); end
        @(posedge clk); #1;
        n_tests++; if (m01_tvalid !== 1'b0) begin n_fail++; $display("FAIL single_m01_drop: got %b want 0", m01_tvalid); end
    endtask

    task automatic test_saturation();
        int acc;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            s00_tvalid = 1'b1; s00_tdata = 64'(32'hC0 + acc); s00_tuser = 8'(16 + acc);
            #1;
            if (s00_tready) acc++;
            @(posedge clk); #1;
        end
        n_tests++; if (acc !== 4) begin n_fail++; $display("FAIL sat_accepted: got %0d want 4", acc); end
        n_tests++; if (s00_tready !== 1'b0) begin n_fail++; $display("FAIL sat_tready: got %b want 0", s00_tready); end
        n_tests++; if (outstanding !== OW'(4)) begin n_fail++; $display("FAIL sat_out4: got %0d want 4", outstanding); end
        s01_tvalid = 1'b1; s01_tdata = 64'h0000_0000_0000_0100;
        #1;
        n_tests++; if (s00_tready !== 1'b0) begin n_fail++; $display("FAIL sat_no_accept_at_full: got %b want 0", s00_tready); end
        @(posedge clk); #1; s01_tvalid = 1'b0; exp_miss++;
        n_tests++; if (outstanding !== OW'(3)) begin n_fail++; $display("FAIL sat_out3: got %0d want 3", outstanding); end
        n_tests++; if (m01_tuser !== 8'h10) begin n_fail++; $display("FAIL sat_first_tag: got %h want 10", m01_tuser); end
        n_tests++; if (m01_tdata !== 64'h100) begin n_fail++; $display("FAIL sat_first_data: got %h want 100", m01_tdata); end
        n_tests++; if (s00_tready !== 1'b1) begin n_fail++; $display("FAIL sat_slot_freed: got %b want 1", s00_tready); end
        @(posedge clk); #1; s00_tvalid = 1'b0;
        n_tests++; if (outstanding !== OW'(4)) begin n_fail++; $display("FAIL sat_fifth_out: got %0d want 4", outstanding); end
        n_tests++; if (m00_tdata !== 64'hC4) begin n_fail++; $display("FAIL sat_fifth_key: got %h want c4", m00_tdata); end
        for (int j = 0; j < 4; j++) begin
            s01_tvalid = 1'b1; s01_tdata = {31'b0, 1'b1, 32'(32'h200 + j)};
            @(posedge clk); #1; exp_hit++;
            n_tests++; if (m01_tuser !== 8'(17 + j)) begin n_fail++; $display("FAIL sat_drain_tag%0d: got %h want %h", j, m01_tuser, 8'(17 + j)); end
            n_tests++; if (m01_tdata !== {31'b0, 1'b1, 32'(32'h200 + j)}) begin n_fail++; $display("FAIL sat_drain_data%0d: got %h", j, m01_tdata); end
        end
        s01_tvalid = 1'b0;
        n_tests++; if (outstanding !== OW'(0)) begin n_fail++; $display("FAIL sat_drained: got %0d want 0", outstanding); end
        n_tests++; if (hit_count !== exp_hit) begin n_fail++; $display("FAIL sat_hit: got %0d want %0d", hit_count, exp_hit); end
        n_tests++; if (miss_count !== exp_miss) begin n_fail++; $display("FAIL sat_miss: got %0d want %0d", miss_count, exp_miss); end
    endtask

    task automatic test_ordering();
        int          req_done, k, pi, rj, pc, rc, cc;
        logic        pfire, rfire, h;
        logic [63:0] exp_data;
        apply_reset();
        req_done = 0; k = 0; pi = 0; rj = 0; pc = 0; rc = 0; cc = 0;
        fork
            begin
                while (pi < 10 && pc < 400) begin
                    s00_tvalid = 1'b1; s00_tdata = 64'(32'h1000 + pi); s00_tuser = 8'(pi);
                    @(negedge clk); pfire = s00_tready;
                    @(posedge clk); #1;
                    if (pfire) begin pi++; req_done = pi; end
                    pc++;
                end
                s00_tvalid = 1'b0;
            end
            begin
                while (rj < 10 && rc < 400) begin
                    if (rj < req_done) begin
                        h = (rj % 2 == 0);
                        s01_tvalid = 1'b1; s01_tdata = {31'b0, h, 32'(32'hA000 + rj)};
                    end else begin
                        s01_tvalid = 1'b0;
                    end
                    @(negedge clk); rfire = s01_tvalid && s01_tready;
                    @(posedge clk); #1;
                    if (rfire) rj++;
                    rc++;
                end
                s01_tvalid = 1'b0;
            end
            begin
                while (k < 10 && cc < 400) begin
                    m01_tready = 1'($urandom_range(0, 1));
                    @(negedge clk);
                    if (m01_tvalid && m01_tready) begin
                        exp_data = {31'b0, (k % 2 == 0), 32'(32'hA000 + k)};
                        n_tests++; if (m01_tuser !== 8'(k)) begin n_fail++; $display("FAIL order_tag%0d: got %h want %h", k, m01_tuser, 8'(k)); end
                        n_tests++; if (m01_tdata !== exp_data) begin n_fail++; $display("FAIL order_data%0d: got %h want %h", k, m01_tdata, exp_data); end
                        k++;
                    end
                    @(posedge clk); #1;
                    cc++;
                end
                m01_tready = 1'b1;
            end
        join
        exp_hit = 32'd5; exp_miss = 32'd5;
        n_tests++; if (k !== 10) begin n_fail++; $display("FAIL order_count: got %0d results want 10", k); end
        n_tests++; if (hit_count !== exp_hit) begin n_fail++; $display("FAIL order_hit: got %0d want 5", hit_count); end
        n_tests++; if (miss_count !== exp_miss) begin n_fail++; $display("FAIL order_miss: got %0d want 5", miss_count); end
        n_tests++; if (outstanding !== OW'(0)) begin n_fail++; $display("FAIL order_out: got %0d want 0", outstanding); end
    endtask

    task automatic test_backpressure();
        m00_tready = 1'b0;
        s00_tvalid = 1'b1; s00_tdata = 64'hDEAD_BEEF_0000_0001; s00_tuser = 8'h33;
        @(posedge clk); #1;
        s00_tdata = 64'hDEAD_BEEF_0000_0002; s00_tuser = 8'h34;
        for (int c = 0; c < 5; c++) begin
            n_tests++; if (m00_tvalid !== 1'b1) begin n_fail++; $display("FAIL bp_m00_valid%0d: got %b want 1", c, m00_tvalid); end
            n_tests++; if (m00_tdata !== 64'hDEAD_BEEF_0000_0001) begin n_fail++; $display("FAIL bp_m00_data%0d: got %h", c, m00_tdata); end
            n_tests++; if (s00_tready !== 1'b0) begin n_fail++; $display("FAIL bp_s00_tready%0d: got %b want 0", c, s00_tready); end
            @(posedge clk); #1;
        end
        s00_tvalid = 1'b0; m00_tready = 1'b1;
        @(posedge clk); #1;
        n_tests++; if (m00_tvalid !== 1'b0) begin n_fail++; $display("FAIL bp_m00_release: got %b want 0", m00_tvalid); end
        n_tests++; if (outstanding !== OW'(1)) begin n_fail++; $display("FAIL bp_out1: got %0d want 1", outstanding); end
        m01_tready = 1'b0;
        s01_tvalid = 1'b1; s01_tdata = 64'hFFFF_FFFF_0000_0055;
        @(posedge clk); #1; exp_hit++;
        s01_tdata = 64'h0000_0000_0000_0066;
        for (int c = 0; c < 3; c++) begin
            n_tests++; if (s01_tready !== 1'b0) begin n_fail++; $display("FAIL bp_s01_tready%0d: got %b want 0", c, s01_tready); end
            n_tests++; if (m01_tvalid !== 1'b1) begin n_fail++; $display("FAIL bp_m01_valid%0d: got %b want 1", c, m01_tvalid); end
            n_tests++; if (m01_tdata !== 64'h0000_0001_0000_0055) begin n_fail++; $display("FAIL bp_m01_data%0d: got %h want 100000055", c, m01_tdata); end
            n_tests++; if (m01_tuser !== 8'h33) begin n_fail++; $display("FAIL bp_m01_tag%0d: got %h want 33", c, m01_tuser); end
            @(posedge clk); #1;
        end
        s01_tvalid = 1'b0; m01_tready = 1'b1;
        @(posedge clk); #1;
        n_tests++; if (m01_tvalid !== 1'b0) begin n_fail++; $display("FAIL bp_m01_release: got %b want 0", m01_tvalid); end
        n_tests++; if (outstanding !== OW'(0)) begin n_fail++; $display("FAIL bp_out0: got %0d want 0", outstanding); end
        n_tests++; if (hit_count !== exp_hit) begin n_fail++; $display("FAIL bp_hit: got %0d want %0d", hit_count, exp_hit); end
        n_tests++; if (unexpected_resp !== 1'b0) begin n_fail++; $display("FAIL bp_no_unexpected: got %b want 0", unexpected_resp); end
    endtask

    task automatic test_unexpected();
        s01_tvalid = 1'b1; s01_tdata = 64'h0000_0001_0000_0BAD;
        #1;
        n_tests++; if (s01_tready !== 1'b1) begin n_fail++; $display("FAIL unexp_tready: got %b want 1", s01_tready); end
        @(posedge clk); #1; s01_tvalid = 1'b0;
        n_tests++; if (unexpected_resp !== 1'b1) begin n_fail++; $display("FAIL unexp_pulse: got %b want 1", unexpected_resp); end
        n_tests++; if (m01_tvalid !== 1'b0) begin n_fail++; $display("FAIL unexp_m01: got %b want 0", m01_tvalid); end
        n_tests++; if (hit_count !== exp_hit) begin n_fail++; $display("FAIL unexp_hit: got %0d want %0d", hit_count, exp_hit); end
        n_tests++; if (miss_count !== exp_miss) begin n_fail++; $display("FAIL unexp_miss: got %0d want %0d", miss_count, exp_miss); end
        n_tests++; if (outstanding !== OW'(0)) begin n_fail++; $display("FAIL unexp_out: got %0d want 0", outstanding); end
        @(posedge clk); #1;
        n_tests++; if (unexpected_resp !== 1'b0) begin n_fail++; $display("FAIL unexp_one_cycle: got %b want 0", unexpected_resp); end
    endtask

    task automatic test_simultaneous_reset();
        for (int i = 0; i < 4; i++) begin
            s00_tvalid = 1'b1; s00_tdata = 64'(32'h300 + i); s00_tuser = 8'(32 + i);
            @(posedge clk); #1;
        end
        s00_tvalid = 1'b0;
        n_tests++; if (outstanding !== OW'(4)) begin n_fail++; $display("FAIL sim_fill: got %0d want 4", outstanding); end
        s01_tvalid = 1'b1; s01_tdata = 64'h0000_0001_0000_0001;
        @(posedge clk); #1; exp_hit++;
        n_tests++; if (outstanding !== OW'(3)) begin n_fail++; $display("FAIL sim_out3: got %0d want 3", outstanding); end
        n_tests++; if (m01_tuser !== 8'h20) begin n_fail++; $display("FAIL sim_tag20: got %h want 20", m01_tuser); end
        s00_tvalid = 1'b1; s00_tdata = 64'h304; s00_tuser = 8'h24;
        s01_tdata = 64'h0000_0000_0000_0002;
        #1;
        n_tests++; if (s00_tready !== 1'b1) begin n_fail++; $display("FAIL sim_accept_ready: got %b want 1", s00_tready); end
        @(posedge clk); #1; exp_miss++;
        s01_tvalid = 1'b0; s00_tdata = 64'h305; s00_tuser = 8'h25;
        n_tests++; if (outstanding !== OW'(3)) begin n_fail++; $display("FAIL sim_unchanged: got %0d want 3", outstanding); end
        n_tests++; if (m01_tuser !== 8'h21) begin n_fail++; $display("FAIL sim_tag21: got %h want 21", m01_tuser); end
        n_tests++; if (m00_tdata !== 64'h304) begin n_fail++; $display("FAIL sim_key: got %h want 304", m00_tdata); end
        @(posedge clk); #1; s00_tvalid = 1'b0;
        n_tests++; if (outstanding !== OW'(4)) begin n_fail++; $display("FAIL sim_out4: got %0d want 4", outstanding); end
        n_tests++; if (s00_tready !== 1'b0) begin n_fail++; $display("FAIL sim_full_tready: got %b want 0", s00_tready); end
        n_tests++; if (hit_count !== exp_hit) begin n_fail++; $display("FAIL sim_hit: got %0d want %0d", hit_count, exp_hit); end
        aresetn = 1'b0;
        #1;
        n_tests++; if (outstanding !== OW'(0)) begin n_fail++; $display("FAIL midrst_out: got %0d want 0", outstanding); end
        n_tests++; if (m00_tvalid !== 1'b0) begin n_fail++; $display("FAIL midrst_m00: got %b want 0", m00_tvalid); end
        n_tests++; if (m01_tvalid !== 1'b0) begin n_fail++; $display("FAIL midrst_m01: got %b want 0", m01_tvalid); end
        n_tests++; if (hit_count !== 32'd0) begin n_fail++; $display("FAIL midrst_hit: got %0d want 0", hit_count); end
        n_tests++; if (miss_count !== 32'd0) begin n_fail++; $display("FAIL midrst_miss: got %0d want 0", miss_count); end
        n_tests++; if (s00_tready !== 1'b0) begin n_fail++; $display("FAIL midrst_tready: got %b want 0", s00_tready); end
        @(posedge clk); #1 aresetn = 1'b1;
        exp_hit = '0; exp_miss = '0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            n_tests++; if (m01_tvalid !== 1'b0) begin n_fail++; $display("FAIL midrst_stale%0d: got %b want 0", c, m01_tvalid); end
        end
        s00_tvalid = 1'b1; s00_tdata = 64'h777; s00_tuser = 8'h77;
        @(posedge clk); #1; s00_tvalid = 1'b0;
        s01_tvalid = 1'b1; s01_tdata = 64'h0000_0000_0000_0099;
        @(posedge clk); #1; s01_tvalid = 1'b0; exp_miss++;
        n_tests++; if (m01_tuser !== 8'h77) begin n_fail++; $display("FAIL postrst_tag: got %h want 77", m01_tuser); end
        n_tests++; if (m01_tdata !== 64'h99) begin n_fail++; $display("FAIL postrst_data: got %h want 99", m01_tdata); end
        n_tests++; if (miss_count !== exp_miss) begin n_fail++; $display("FAIL postrst_miss: got %0d want 1", miss_count); end
        n_tests++; if (outstanding !== OW'(0)) begin n_fail++; $display("FAIL postrst_out: got %0d want 0", outstanding); end
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        exp_hit = '0; exp_miss = '0;
        aresetn = 1'b1;
        s00_tvalid = 1'b0; s00_tdata = '0; s00_tuser = '0;
        s01_tvalid = 1'b0; s01_tdata = '0;
        m00_tready = 1'b1; m01_tready = 1'b1;
        test_reset();
        test_single();
        test_saturation();
        test_ordering();
        test_backpressure();
        test_unexpected();
        test_simultaneous_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
